// File: rtl/cnt_seq_ctrl.sv
// Sequencer that walks an externally held address counter, reads one memory entry
// per step and forwards it on a valid/ready stream, with abort and end-of-transfer pulse.
module cnt_seq_ctrl #(
  parameter int CNT_WIDTH   = 7,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 100
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [CNT_WIDTH-1:0]  cnt_i,
  output logic                  en_o,
  output logic                  done_o,
  output logic                  rd_en_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_SEND,
    S_DONE
  } state_e;

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(NUM_ENTRIES - 1);

  state_e                state_q;
  logic                  rd_en_q;
  logic                  m_valid_q;
  logic                  done_q;
  logic                  busy_q;
  logic [DATA_WIDTH-1:0] m_data_q;

  logic handshake;
  logic last_entry;

  // An abort in SEND wins over a simultaneous ready, so no transfer is counted.
  assign handshake  = m_valid_q & m_ready_i & ~abort_i;
  assign last_entry = (cnt_i == LAST_CNT);
  assign en_o       = handshake & ~last_entry;

  assign rd_en_o   = rd_en_q;
  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
  assign done_o    = done_q;
  assign busy_o    = busy_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      rd_en_q   <= 1'b0;
      m_valid_q <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      m_data_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            state_q <= S_READ;
            rd_en_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          rd_en_q <= 1'b0;
          if (abort_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          m_data_q <= rd_data_i;
          if (abort_i) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            state_q   <= S_SEND;
            m_valid_q <= 1'b1;
          end
        end
        S_SEND: begin
          if (abort_i || (handshake && last_entry)) begin
            state_q   <= S_DONE;
            m_valid_q <= 1'b0;
            done_q    <= 1'b1;
          end else if (handshake) begin
            state_q   <= S_READ;
            m_valid_q <= 1'b0;
            rd_en_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q   <= S_IDLE;
          rd_en_q   <= 1'b0;
          m_valid_q <= 1'b0;
          done_q    <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cnt_seq_ctrl.sv
// Directed bench for cnt_seq_ctrl: a 4-entry instance for directed scenarios and a
// default 100-entry instance under random backpressure, each with its own counter and memory.
module tb_cnt_seq_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: NUM_ENTRIES=4
  logic        start_a = 1'b0, abort_a = 1'b0, ready_a = 1'b0;
  logic [6:0]  cnt_a;
  logic [31:0] rd_data_a;
  logic        en_a, done_a, rd_en_a, valid_a, busy_a;
  logic [31:0] data_a;

  cnt_seq_ctrl #(.CNT_WIDTH(7), .DATA_WIDTH(32), .NUM_ENTRIES(4)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .abort_i(abort_a), .cnt_i(cnt_a),
    .en_o(en_a), .done_o(done_a), .rd_en_o(rd_en_a), .rd_data_i(rd_data_a),
    .m_valid_o(valid_a), .m_data_o(data_a), .m_ready_i(ready_a), .busy_o(busy_a)
  );

  // Instance B: default parameters
  logic        start_b = 1'b0, abort_b = 1'b0, ready_b = 1'b0;
  logic [6:0]  cnt_b;
  logic [31:0] rd_data_b;
  logic        en_b, done_b, rd_en_b, valid_b, busy_b;
  logic [31:0] data_b;

  cnt_seq_ctrl u_dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .abort_i(abort_b), .cnt_i(cnt_b),
    .en_o(en_b), .done_o(done_b), .rd_en_o(rd_en_b), .rd_data_i(rd_data_b),
    .m_valid_o(valid_b), .m_data_o(data_b), .m_ready_i(ready_b), .busy_o(busy_b)
  );

  // External counters and memories (data = address + 0x10, one cycle read latency)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else begin
      if (done_a) cnt_a <= '0; else if (en_a) cnt_a <= cnt_a + 7'd1;
      if (done_b) cnt_b <= '0; else if (en_b) cnt_b <= cnt_b + 7'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rd_en_a) rd_data_a <= 32'(cnt_a) + 32'h10;
    if (rd_en_b) rd_data_b <= 32'(cnt_b) + 32'h10;
  end

  // Event recorders
  int          cyc = 0;
  int          en_cnt_a = 0, done_cnt_a = 0, both_a = 0, last_hs_cyc_a = 0;
  int          en_cnt_b = 0, done_cnt_b = 0, both_b = 0;
  logic [31:0] hs_a[$];
  logic [31:0] hs_b[$];

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (en_a) en_cnt_a = en_cnt_a + 1;
    if (done_a) done_cnt_a = done_cnt_a + 1;
    if (en_a && done_a) both_a = both_a + 1;
    if (valid_a && ready_a && !abort_a) begin
      hs_a.push_back(data_a);
      last_hs_cyc_a = cyc;
    end
    if (en_b) en_cnt_b = en_cnt_b + 1;
    if (done_b) done_cnt_b = done_cnt_b + 1;
    if (en_b && done_b) both_b = both_b + 1;
    if (valid_b && ready_b) hs_b.push_back(data_b);
  end

  int errors = 0;
  int checks = 0;

  task automatic wait_done_a(input string name);
    int n;
    n = 0;
    while (done_a !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_a !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: done_o=%b, required 1 within 200 cycles", name, done_a);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({en_a, done_a, rd_en_a, valid_a, busy_a} !== 5'b0 || data_a !== 32'h0) begin
      errors++;
      $display("FAIL reset_outputs: en/done/rd_en/valid/busy=%b data=%h, required 00000 / 0",
               {en_a, done_a, rd_en_a, valid_a, busy_a}, data_a);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rd_en=%b, required 0 0", busy_a, rd_en_a);
    end
  endtask

  task automatic test_basic();
    int en0, done0, hs0;
    en0 = en_cnt_a; done0 = done_cnt_a; hs0 = hs_a.size();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (rd_en_a !== 1'b1 || busy_a !== 1'b1 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_read_cycle: rd_en=%b busy=%b valid=%b, required 1 1 0", rd_en_a, busy_a, valid_a);
    end
    @(negedge clk);
    checks++;
    if (rd_en_a !== 1'b0 || valid_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_wait_cycle: rd_en=%b valid=%b, required 0 0", rd_en_a, valid_a);
    end
    @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h10 || en_a !== 1'b1) begin
      errors++;
      $display("FAIL basic_first_send: valid=%b data=%h en=%b, required 1 00000010 1", valid_a, data_a, en_a);
    end
    wait_done_a("basic");
    checks++;
    if (last_hs_cyc_a !== cyc) begin
      errors++;
      $display("FAIL basic_done_latency: last handshake cycle=%0d done cycle=%0d, required done one cycle later",
               last_hs_cyc_a, cyc + 1);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL basic_done_one_cycle: done=%b busy=%b, required 0 0", done_a, busy_a);
    end
    checks++;
    if (hs_a.size() - hs0 != 4 || hs_a[hs0] !== 32'h10 || hs_a[hs0+1] !== 32'h11 ||
        hs_a[hs0+2] !== 32'h12 || hs_a[hs0+3] !== 32'h13) begin
      errors++;
      $display("FAIL basic_stream: %0d beats received, required 10,11,12,13", hs_a.size() - hs0);
    end
    checks++;
    if (en_cnt_a - en0 != 3 || done_cnt_a - done0 != 1) begin
      errors++;
      $display("FAIL basic_counts: en=%0d done=%0d, required 3 1", en_cnt_a - en0, done_cnt_a - done0);
    end
  endtask

  task automatic test_backpressure();
    int en0, hs0;
    en0 = en_cnt_a; hs0 = hs_a.size();
    ready_a = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (valid_a !== 1'b1 || data_a !== 32'h10 || en_a !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d: valid=%b data=%h en=%b, required 1 00000010 0", i, valid_a, data_a, en_a);
      end
      @(negedge clk);
    end
    ready_a = 1'b1;
    #1;
    checks++;
    if (en_a !== 1'b1 || data_a !== 32'h10) begin
      errors++;
      $display("FAIL bp_release: en=%b data=%h, required 1 00000010", en_a, data_a);
    end
    wait_done_a("bp");
    @(negedge clk);
    checks++;
    if (hs_a.size() - hs0 != 4 || en_cnt_a - en0 != 3 || hs_a[hs0+3] !== 32'h13) begin
      errors++;
      $display("FAIL bp_totals: beats=%0d en=%0d, required 4 3", hs_a.size() - hs0, en_cnt_a - en0);
    end
  endtask

  task automatic test_abort();
    int en0, hs0, done0;
    en0 = en_cnt_a; hs0 = hs_a.size(); done0 = done_cnt_a;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (valid_a !== 1'b1 || data_a !== 32'h11) begin
      errors++;
      $display("FAIL abort_entry2_send: valid=%b data=%h, required 1 00000011", valid_a, data_a);
    end
    abort_a = 1'b1;
    #1;
    checks++;
    if (en_a !== 1'b0) begin
      errors++;
      $display("FAIL abort_en_suppressed: en=%b, required 0", en_a);
    end
    @(negedge clk);
    abort_a = 1'b0;
    checks++;
    if (done_a !== 1'b1 || valid_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_done: done=%b valid=%b busy=%b, required 1 0 1", done_a, valid_a, busy_a);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0 || en_cnt_a - en0 != 1 || hs_a.size() - hs0 != 1 ||
        done_cnt_a - done0 != 1) begin
      errors++;
      $display("FAIL abort_idle: done=%b busy=%b en=%0d beats=%0d, required 0 0 1 1",
               done_a, busy_a, en_cnt_a - en0, hs_a.size() - hs0);
    end
  endtask

  task automatic test_back_to_back();
    int hs0;
    hs0 = hs_a.size();
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b1 || rd_en_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_start_ignored: busy=%b rd_en=%b, required 1 0", busy_a, rd_en_a);
    end
    wait_done_a("b2b_first");
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || rd_en_a !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle_gap: busy=%b rd_en=%b, required 0 0", busy_a, rd_en_a);
    end
    @(negedge clk);
    start_a = 1'b0;
    checks++;
    if (rd_en_a !== 1'b1 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL b2b_second_read: rd_en=%b busy=%b, required 1 1", rd_en_a, busy_a);
    end
    wait_done_a("b2b_second");
    @(negedge clk);
    checks++;
    if (hs_a.size() - hs0 != 8 || hs_a[hs0+4] !== 32'h10 || hs_a[hs0+7] !== 32'h13) begin
      errors++;
      $display("FAIL b2b_beats: beats=%0d, required 8 with second run 10..13", hs_a.size() - hs0);
    end
  endtask

  task automatic test_reset_mid();
    int done0, hs0;
    ready_a = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (valid_a !== 1'b0 || rd_en_a !== 1'b0 || busy_a !== 1'b1 || cnt_a !== 7'd1) begin
      errors++;
      $display("FAIL rstmid_in_wait: valid=%b rd_en=%b busy=%b cnt=%0d, required 0 0 1 1",
               valid_a, rd_en_a, busy_a, cnt_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({en_a, done_a, rd_en_a, valid_a, busy_a} !== 5'b0 || data_a !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_async: en/done/rd_en/valid/busy=%b data=%h, required 00000 / 0",
               {en_a, done_a, rd_en_a, valid_a, busy_a}, data_a);
    end
    @(negedge clk);
    rst_n = 1'b1;
    done0 = done_cnt_a;
    repeat (4) @(negedge clk);
    checks++;
    if (done_cnt_a != done0 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: done pulses=%0d busy=%b, required 0 0", done_cnt_a - done0, busy_a);
    end
    hs0 = hs_a.size();
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a("rstmid_fresh");
    @(negedge clk);
    checks++;
    if (hs_a.size() - hs0 != 4 || hs_a[hs0] !== 32'h10 || hs_a[hs0+3] !== 32'h13) begin
      errors++;
      $display("FAIL rstmid_fresh_run: beats=%0d, required 4 starting at 10", hs_a.size() - hs0);
    end
  endtask

  task automatic test_random_default();
    int n, bad;
    start_b = 1'b1;
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (done_b !== 1'b1 && n < 5000) begin
      ready_b = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    checks++;
    if (done_b !== 1'b1) begin
      errors++;
      $display("FAIL rand_timeout: done_o=%b, required 1 within 5000 cycles", done_b);
    end
    ready_b = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < hs_b.size(); i++)
      if (hs_b[i] !== 32'(i) + 32'h10) bad++;
    checks++;
    if (hs_b.size() != 100 || bad != 0) begin
      errors++;
      $display("FAIL rand_stream: beats=%0d out_of_order=%0d, required 100 0", hs_b.size(), bad);
    end
    checks++;
    if (en_cnt_b != 99 || done_cnt_b != 1 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL rand_counts: en=%0d done=%0d busy=%b, required 99 1 0", en_cnt_b, done_cnt_b, busy_b);
    end
    checks++;
    if (both_a != 0 || both_b != 0) begin
      errors++;
      $display("FAIL en_done_overlap: coincident cycles a=%0d b=%0d, required 0 0", both_a, both_b);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_abort();
    test_back_to_back();
    test_reset_mid();
    test_random_default();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
